// File: rtl/ysyx_2022040010_rr_arbit_pkg.sv
// Shared constants for the round-robin bus arbiter.
package ysyx_2022040010_rr_arbit_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Bus direction encoding on rw_req_o
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Transfer size: always a full 8-byte beat
  localparam logic [1:0] SIZE_8B = 2'b11;

  // Width of the bus transaction id
  localparam int unsigned ID_W = 4;

endpackage

// File: rtl/ysyx_2022040010_rr_pick.sv
// Rotating priority selector: first requester at or after start, wrapping.
module ysyx_2022040010_rr_pick
  import ysyx_2022040010_rr_arbit_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  localparam int unsigned IW  = $clog2(N);
  localparam int unsigned IW1 = IW + 1;

  logic [IW1-1:0] idx;

  // Walk channels from start, modulo N, and take the first active one
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW1'(start) + IW1'(i);
      if (idx >= IW1'(N)) begin
        idx = idx - IW1'(N);
      end
      if (!valid && req[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        valid              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_2022040010_rr_arbit.sv
// Arbitrates per-channel refill/writeback requests onto one shared bus.
module ysyx_2022040010_rr_arbit
  import ysyx_2022040010_rr_arbit_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RR_EN  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_re_i,
  input  logic [NUM_CH-1:0]          req_we_i,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_CH*DATA_W/8-1:0] req_mask_i,
  output logic [NUM_CH-1:0]          resp_valid_o,
  output logic [DATA_W-1:0]          resp_rdata_o,
  output logic                       rw_valid_o,
  input  logic                       rw_ready_i,
  output logic                       rw_req_o,
  output logic [ADDR_W-1:0]          rw_addr_o,
  output logic [1:0]                 rw_size_o,
  output logic [DATA_W/8-1:0]        w_mask_o,
  output logic [DATA_W-1:0]          data_write_o,
  input  logic [DATA_W-1:0]          data_read_i,
  output logic [ID_W-1:0]            rw_id_o,
  input  logic [ID_W-1:0]            rw_id_i,
  output logic                       stall_o,
  output logic                       id_err_o
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_CH);

  logic [1:0]        state_q, state_n;
  logic [IDX_W-1:0]  last_q;
  logic              excl_q;
  logic              re_q;

  logic [NUM_CH-1:0] excl_vec, req_vec, pick_gnt;
  logic              pick_vld, grant_ok;
  logic [IDX_W-1:0]  start_idx, sel_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_mask;
  logic              sel_re, sel_we;
  logic              bus_act;

  // Hold the channel just served out of the first IDLE cycle after DONE
  assign excl_vec = excl_q ? (NUM_CH'(1) << last_q) : '0;
  assign req_vec  = (req_re_i | req_we_i) & ~excl_vec;

  // Search start: one past the last grant, or always channel 0 in fixed mode
  assign start_idx = (RR_EN == 0)                       ? '0 :
                     (last_q == IDX_W'(NUM_CH - 1))     ? '0 :
                                                          last_q + IDX_W'(1);

  ysyx_2022040010_rr_pick #(
    .N(NUM_CH)
  ) u_pick (
    .req   (req_vec),
    .start (start_idx),
    .grant (pick_gnt),
    .valid (pick_vld)
  );

  // Fixed mode idles through the exclusion cycle so the top channel keeps winning
  assign grant_ok = pick_vld && !((RR_EN == 0) && excl_q);

  // Mux the winning channel's request fields
  always_comb begin
    sel_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    sel_re    = 1'b0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pick_gnt[i]) begin
        sel_idx   = IDX_W'(i);
        sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
        sel_mask  = req_mask_i[i*MASK_W +: MASK_W];
        sel_re    = req_re_i[i];
        sel_we    = req_we_i[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (grant_ok)   state_n = sel_we ? ST_WB : ST_RD;
      ST_WB:   if (rw_ready_i) state_n = re_q ? ST_RD : ST_DONE;
      ST_RD:   if (rw_ready_i) state_n = ST_DONE;
      ST_DONE:                 state_n = ST_IDLE;
      default:                 state_n = ST_IDLE;
    endcase
  end

  assign bus_act = (state_q == ST_WB) || (state_q == ST_RD);

  // State, latched request and registered bus/response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_q       <= IDX_W'(NUM_CH - 1);
      excl_q       <= 1'b0;
      re_q         <= 1'b0;
      rw_valid_o   <= 1'b0;
      rw_req_o     <= RW_READ;
      rw_addr_o    <= '0;
      w_mask_o     <= '0;
      data_write_o <= '0;
      rw_id_o      <= '0;
      resp_valid_o <= '0;
      resp_rdata_o <= '0;
      id_err_o     <= 1'b0;
    end else begin
      state_q      <= state_n;
      excl_q       <= (state_q == ST_DONE);
      rw_valid_o   <= (state_n == ST_WB) || (state_n == ST_RD);
      rw_req_o     <= (state_n == ST_WB) ? RW_WRITE : RW_READ;
      resp_valid_o <= (state_n == ST_DONE) ? (NUM_CH'(1) << last_q) : '0;
      if ((state_q == ST_IDLE) && grant_ok) begin
        last_q       <= sel_idx;
        rw_id_o      <= ID_W'(sel_idx);
        rw_addr_o    <= sel_addr;
        data_write_o <= sel_wdata;
        w_mask_o     <= sel_mask;
        re_q         <= sel_re;
      end
      if ((state_q == ST_RD) && rw_ready_i) begin
        resp_rdata_o <= data_read_i;
      end
      if (bus_act && rw_ready_i && (rw_id_i != rw_id_o)) begin
        id_err_o <= 1'b1;
      end
    end
  end

  assign rw_size_o = SIZE_8B;

  // Stall while anyone asks or a transfer is open; release in the DONE cycle
  assign stall_o = (state_q != ST_DONE) &&
                   ((|(req_re_i | req_we_i)) || (state_q != ST_IDLE));

endmodule

// File: tb/tb_ysyx_2022040010_rr_arbit.sv
// Scoreboard bench for the round-robin bus arbiter.
module tb_ysyx_2022040010_rr_arbit;

  localparam int unsigned NCH = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned MW  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NCH-1:0]    req_re, req_we;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH*MW-1:0] req_mask;
  logic [NCH-1:0]    resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              rw_valid, rw_ready, rw_req;
  logic [AW-1:0]     rw_addr;
  logic [1:0]        rw_size;
  logic [MW-1:0]     w_mask;
  logic [DW-1:0]     data_write, data_read;
  logic [3:0]        rw_id, rw_id_in;
  logic              stall, id_err;

  // Fixed-priority instance with an auto-responding bus
  logic              fp_en;
  logic [NCH-1:0]    fp_re, fp_resp;
  logic [DW-1:0]     fp_rdata, fp_wdata;
  logic              fp_valid, fp_ready, fp_req, fp_stall, fp_err;
  logic [AW-1:0]     fp_addr;
  logic [1:0]        fp_size;
  logic [MW-1:0]     fp_mask;
  logic [3:0]        fp_id;
  assign fp_re = fp_en ? req_re : '0;

  ysyx_2022040010_rr_arbit dut (
    .clock(clock), .reset(reset),
    .req_re_i(req_re), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_mask_i(req_mask),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .rw_valid_o(rw_valid), .rw_ready_i(rw_ready), .rw_req_o(rw_req),
    .rw_addr_o(rw_addr), .rw_size_o(rw_size), .w_mask_o(w_mask),
    .data_write_o(data_write), .data_read_i(data_read),
    .rw_id_o(rw_id), .rw_id_i(rw_id_in), .stall_o(stall), .id_err_o(id_err)
  );

  ysyx_2022040010_rr_arbit #(.RR_EN(0)) dut_fp (
    .clock(clock), .reset(reset),
    .req_re_i(fp_re), .req_we_i('0), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_mask_i(req_mask),
    .resp_valid_o(fp_resp), .resp_rdata_o(fp_rdata),
    .rw_valid_o(fp_valid), .rw_ready_i(fp_ready), .rw_req_o(fp_req),
    .rw_addr_o(fp_addr), .rw_size_o(fp_size), .w_mask_o(fp_mask),
    .data_write_o(fp_wdata), .data_read_i('0),
    .rw_id_o(fp_id), .rw_id_i(fp_id), .stall_o(fp_stall), .id_err_o(fp_err)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    logic [3:0]    id;
  } bus_t;

  typedef struct {
    logic [NCH-1:0] onehot;
    logic [DW-1:0]  data;
    logic           chk_data;
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];
  bus_t  mb;
  resp_t mr;
  int    checks = 0;
  int    errors = 0;
  int    fp_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic exp_bus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, input logic [3:0] id);
    bus_t b;
    b.wr = wr; b.addr = a; b.wdata = d; b.mask = m; b.id = id;
    bus_q.push_back(b);
  endtask

  task automatic exp_resp(input logic [NCH-1:0] oh, input logic [DW-1:0] d, input logic cd);
    resp_t r;
    r.onehot = oh; r.data = d; r.chk_data = cd;
    resp_q.push_back(r);
  endtask

  // Wait for a bus request, then complete it after lat cycles of valid
  task automatic serve(input int lat, input logic [DW-1:0] d, input logic [3:0] id);
    int n = 0;
    while (rw_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout actual=no rw_valid expected=rw_valid within 20 cycles");
    end
    if (lat > 1) cyc(lat - 1);
    data_read = d;
    rw_id_in  = id;
    rw_ready  = 1'b1;
    cyc();
    rw_ready  = 1'b0;
  endtask

  // Bus and response monitors
  always @(negedge clock) begin
    if (!reset && rw_valid && rw_ready) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_extra actual=req%0d addr=%h expected=no transfer", rw_req, rw_addr);
      end else begin
        mb = bus_q.pop_front();
        chk("bus_req",  64'(rw_req),  64'(mb.wr));
        chk("bus_addr", 64'(rw_addr), 64'(mb.addr));
        chk("bus_id",   64'(rw_id),   64'(mb.id));
        chk("bus_size", 64'(rw_size), 64'(2'b11));
        if (mb.wr) begin
          chk("bus_wdata", data_write, mb.wdata);
          chk("bus_mask",  64'(w_mask), 64'(mb.mask));
        end
      end
    end
    if (resp_valid != '0) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_extra actual=%b expected=no pulse", resp_valid);
      end else begin
        mr = resp_q.pop_front();
        chk("resp_onehot", 64'(resp_valid), 64'(mr.onehot));
        if (mr.chk_data) chk("resp_rdata", resp_rdata, mr.data);
      end
    end
    if (fp_resp != '0) begin
      fp_pulses++;
      chk("fp_grant", 64'(fp_resp), 64'(3'b001));
    end
  end

  // Fixed-priority bus responder: one-cycle ready per request
  initial begin
    fp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      fp_ready = fp_valid && !fp_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    req_re = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
    rw_ready = 1'b0; data_read = '0; rw_id_in = '0; fp_en = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc();

    // Reset state
    chk("rst_valid", 64'(rw_valid), 64'(0));
    chk("rst_req",   64'(rw_req),   64'(0));
    chk("rst_addr",  64'(rw_addr),  64'(0));
    chk("rst_id",    64'(rw_id),    64'(0));
    chk("rst_resp",  64'(resp_valid), 64'(0));
    chk("rst_rdata", resp_rdata,    64'(0));
    chk("rst_err",   64'(id_err),   64'(0));
    chk("rst_stall", 64'(stall),    64'(0));
    chk("rst_size",  64'(rw_size),  64'(2'b11));

    // Ch1 read-only
    req_addr[1*AW +: AW] = 32'h8000_0040;
    exp_bus(1'b0, 32'h8000_0040, '0, '0, 4'd1);
    exp_resp(3'b010, 64'hDEAD_BEEF_0123_4567, 1'b1);
    req_re = 3'b010;
    cyc();
    chk("lat_valid", 64'(rw_valid), 64'(1));
    chk("rd_req",    64'(rw_req),   64'(0));
    chk("rd_stall",  64'(stall),    64'(1));
    chk("rd_id",     64'(rw_id),    64'(1));
    serve(3, 64'hDEAD_BEEF_0123_4567, 4'd1);
    chk("done_stall", 64'(stall), 64'(0));
    req_re = '0;
    cyc(2);

    // Ch2 write then read
    req_addr[2*AW +: AW]  = 32'h8000_1000;
    req_wdata[2*DW +: DW] = 64'h1122_3344_5566_7788;
    req_mask[2*MW +: MW]  = 8'hFF;
    exp_bus(1'b1, 32'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF, 4'd2);
    exp_bus(1'b0, 32'h8000_1000, '0, '0, 4'd2);
    exp_resp(3'b100, 64'hCAFE_F00D_0000_0002, 1'b1);
    req_re = 3'b100; req_we = 3'b100;
    cyc();
    chk("wb_req", 64'(rw_req), 64'(1));
    serve(2, 64'h0, 4'd2);
    chk("wb_to_rd_req",   64'(rw_req),   64'(0));
    chk("wb_to_rd_valid", 64'(rw_valid), 64'(1));
    serve(2, 64'hCAFE_F00D_0000_0002, 4'd2);
    req_re = '0; req_we = '0;
    cyc(2);

    // Ch0 write-only, data of the response is not checked
    req_addr[0*AW +: AW]  = 32'h8000_3000;
    req_wdata[0*DW +: DW] = 64'hA5A5_5A5A_0F0F_F0F0;
    req_mask[0*MW +: MW]  = 8'h0F;
    exp_bus(1'b1, 32'h8000_3000, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 4'd0);
    exp_resp(3'b001, '0, 1'b0);
    req_we = 3'b001;
    serve(1, 64'h0, 4'd0);
    req_we = '0;
    cyc(2);

    // Address held while requester changes it mid-read
    req_addr[0*AW +: AW] = 32'h8000_2000;
    exp_bus(1'b0, 32'h8000_2000, '0, '0, 4'd0);
    exp_resp(3'b001, 64'h0123_4567_89AB_CDEF, 1'b1);
    req_re = 3'b001;
    cyc();
    req_addr[0*AW +: AW] = 32'h1234_5678;
    cyc();
    chk("addr_hold", 64'(rw_addr), 64'(32'h8000_2000));
    serve(2, 64'h0123_4567_89AB_CDEF, 4'd0);
    req_re = '0;
    cyc(2);

    // Id mismatch is sticky
    req_addr[1*AW +: AW] = 32'h8000_0080;
    exp_bus(1'b0, 32'h8000_0080, '0, '0, 4'd1);
    exp_resp(3'b010, 64'h5555_AAAA_5555_AAAA, 1'b1);
    req_re = 3'b010;
    serve(1, 64'h5555_AAAA_5555_AAAA, 4'd5);
    chk("id_err_set", 64'(id_err), 64'(1));
    req_re = '0;
    cyc(2);
    req_addr[0*AW +: AW] = 32'h8000_00C0;
    exp_bus(1'b0, 32'h8000_00C0, '0, '0, 4'd0);
    exp_resp(3'b001, 64'h7777_0000_7777_0000, 1'b1);
    req_re = 3'b001;
    serve(2, 64'h7777_0000_7777_0000, 4'd0);
    req_re = '0;
    cyc(2);
    chk("id_err_hold", 64'(id_err), 64'(1));

    // Reset during write-back abandons the transfer
    req_addr[2*AW +: AW]  = 32'h8000_4000;
    req_wdata[2*DW +: DW] = 64'h0BAD_0BAD_0BAD_0BAD;
    req_we = 3'b100;
    cyc();
    chk("wb_valid", 64'(rw_valid), 64'(1));
    chk("wb_req2",  64'(rw_req),   64'(1));
    reset = 1'b1; req_we = '0;
    cyc();
    reset = 1'b0;
    chk("rst_wb_valid", 64'(rw_valid),   64'(0));
    chk("rst_wb_req",   64'(rw_req),     64'(0));
    chk("rst_wb_resp",  64'(resp_valid), 64'(0));
    chk("rst_err_clr",  64'(id_err),     64'(0));
    chk("rst_wb_stall", 64'(stall),      64'(0));
    cyc(3);

    // All three requesting: round-robin 0,1,2,0,1,2; fixed instance ch0 only
    for (int c = 0; c < 3; c++) req_addr[c*AW +: AW] = 32'h8000_5000 + 32'(c) * 32'h100;
    for (int k = 0; k < 6; k++) begin
      exp_bus(1'b0, 32'h8000_5000 + 32'(k % 3) * 32'h100, '0, '0, 4'(k % 3));
      exp_resp(3'(1 << (k % 3)), 64'h1000 + 64'(k), 1'b1);
    end
    fp_en = 1'b1;
    req_re = 3'b111;
    for (int k = 0; k < 6; k++) serve(2, 64'h1000 + 64'(k), 4'(k % 3));
    req_re = '0;
    fp_en = 1'b0;
    cyc(10);
    chk("fp_pulses", 64'(fp_pulses >= 3), 64'(1));

    chk("bus_q_empty",  64'(bus_q.size()),  64'(0));
    chk("resp_q_empty", 64'(resp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
